// File: rtl/flash_pkg.sv
// Shared opcode constants, FSM state encoding and JEDEC ID byte selection
// for the SPI flash responder.
package flash_pkg;

   localparam logic [7:0] OP_WREN = 8'h06;
   localparam logic [7:0] OP_WRDI = 8'h04;
   localparam logic [7:0] OP_RDSR = 8'h05;
   localparam logic [7:0] OP_RDID = 8'h9F;
   localparam logic [7:0] OP_READ = 8'h03;
   localparam logic [7:0] OP_PP   = 8'h02;
   localparam logic [7:0] OP_DP   = 8'hB9;
   localparam logic [7:0] OP_RES  = 8'hAB;

   typedef enum logic [2:0] {
      ST_CMD,
      ST_ADDR,
      ST_READ,
      ST_PROG,
      ST_ID,
      ST_STATUS,
      ST_IGNORE
   } state_t;

   // Index 3 and beyond reads as zero once the three ID bytes are exhausted
   function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = id[23:16];
         2'd1:    b = id[15:8];
         2'd2:    b = id[7:0];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit; resets low.
module sync_2ff (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic d_i,
   output logic q_o
);

   logic meta;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         meta <= 1'b0;
         q_o  <= 1'b0;
      end else begin
         meta <= d_i;
         q_o  <= meta;
      end
   end

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash responder: oversamples sck/csn/mosi on clk_i and serves
// READ, PROG, ID, STATUS and power-down commands against a byte memory port.
import flash_pkg::*;

module spi_flash_responder #(
   parameter int          ADDR_WIDTH = 20,
   parameter logic [23:0] JEDEC_ID   = 24'h1F8501
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  sck_i,
   input  logic                  csn_i,
   input  logic                  mosi_i,
   output logic                  miso_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic                  mem_re_o,
   input  logic [7:0]            mem_rdata_i,
   output logic                  mem_we_o,
   output logic [7:0]            mem_wdata_o
);

   logic sck_s, csn_s, mosi_s;
   logic sck_q, csn_q;
   logic sck_rise, sck_fall, csn_rise, csn_fall;

   state_t                state;
   logic                  active, is_read, load_pend;
   logic                  wel, pd, pd_pend, prog_txn;
   logic [2:0]            bit_cnt;
   logic [1:0]            byte_cnt, id_nxt;
   logic [6:0]            shift_in;
   logic [7:0]            shift_out, rx_next, status_byte;
   logic [ADDR_WIDTH-1:0] addr, addr_sr, addr_next, addr_inc, page_inc;

   sync_2ff u_sync_sck  (.clk_i(clk_i), .rstn_i(rstn_i), .d_i(sck_i),  .q_o(sck_s));
   sync_2ff u_sync_csn  (.clk_i(clk_i), .rstn_i(rstn_i), .d_i(csn_i),  .q_o(csn_s));
   sync_2ff u_sync_mosi (.clk_i(clk_i), .rstn_i(rstn_i), .d_i(mosi_i), .q_o(mosi_s));

   // csn resets low alongside its synchronizer, so a csn held low across reset
   // never looks like a fresh falling edge
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         sck_q <= 1'b0;
         csn_q <= 1'b0;
      end else begin
         sck_q <= sck_s;
         csn_q <= csn_s;
      end
   end

   assign sck_rise    = sck_s & ~sck_q;
   assign sck_fall    = ~sck_s & sck_q;
   assign csn_rise    = csn_s & ~csn_q;
   assign csn_fall    = ~csn_s & csn_q;

   assign rx_next     = {shift_in, mosi_s};
   assign addr_next   = {addr_sr[ADDR_WIDTH-2:0], mosi_s};
   assign addr_inc    = addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   assign page_inc    = {addr[ADDR_WIDTH-1:8], addr[7:0] + 8'd1};
   assign id_nxt      = (byte_cnt == 2'd3) ? 2'd3 : byte_cnt + 2'd1;
   assign status_byte = {6'b0, wel, 1'b0};

   // Main protocol FSM; a read issued on an sck rise lands in shift_out two
   // clk_i later, which the 4x clock ratio guarantees precedes the next fall
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state       <= ST_CMD;
         active      <= 1'b0;
         is_read     <= 1'b0;
         load_pend   <= 1'b0;
         wel         <= 1'b0;
         pd          <= 1'b0;
         pd_pend     <= 1'b0;
         prog_txn    <= 1'b0;
         bit_cnt     <= 3'd0;
         byte_cnt    <= 2'd0;
         shift_in    <= 7'd0;
         shift_out   <= 8'd0;
         addr        <= '0;
         addr_sr     <= '0;
         miso_o      <= 1'b0;
         mem_addr_o  <= '0;
         mem_re_o    <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_wdata_o <= 8'd0;
      end else begin
         mem_re_o  <= 1'b0;
         mem_we_o  <= 1'b0;
         load_pend <= mem_re_o;

         if (csn_rise) begin
            active    <= 1'b0;
            state     <= ST_CMD;
            bit_cnt   <= 3'd0;
            byte_cnt  <= 2'd0;
            shift_out <= 8'd0;
            miso_o    <= 1'b0;
            load_pend <= 1'b0;
            prog_txn  <= 1'b0;
            pd_pend   <= 1'b0;
            if (prog_txn) wel <= 1'b0;
            if (pd_pend)  pd  <= 1'b1;
         end else if (csn_fall) begin
            active    <= 1'b1;
            state     <= ST_CMD;
            bit_cnt   <= 3'd0;
            byte_cnt  <= 2'd0;
            shift_out <= 8'd0;
            miso_o    <= 1'b0;
         end else if (active) begin
            if (sck_rise) begin
               bit_cnt  <= bit_cnt + 3'd1;
               shift_in <= rx_next[6:0];
               case (state)
                  ST_CMD: begin
                     if (bit_cnt == 3'd7) begin
                        byte_cnt <= 2'd0;
                        if (pd && rx_next != OP_RES) begin
                           state <= ST_IGNORE;
                        end else begin
                           case (rx_next)
                              OP_WREN: begin wel <= 1'b1; state <= ST_IGNORE; end
                              OP_WRDI: begin wel <= 1'b0; state <= ST_IGNORE; end
                              OP_RDSR: begin state <= ST_STATUS; shift_out <= status_byte; end
                              OP_RDID: begin state <= ST_ID; shift_out <= id_byte(JEDEC_ID, 2'd0); end
                              OP_READ: begin state <= ST_ADDR; is_read <= 1'b1; end
                              OP_PP: begin
                                 prog_txn <= 1'b1;
                                 is_read  <= 1'b0;
                                 state    <= wel ? ST_ADDR : ST_IGNORE;
                              end
                              OP_DP:   begin pd_pend <= 1'b1; state <= ST_IGNORE; end
                              OP_RES:  begin pd <= 1'b0; state <= ST_IGNORE; end
                              default: state <= ST_IGNORE;
                           endcase
                        end
                     end
                  end
                  ST_ADDR: begin
                     addr_sr <= addr_next;
                     if (bit_cnt == 3'd7) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd2) begin
                           byte_cnt <= 2'd0;
                           addr     <= addr_next;
                           if (is_read) begin
                              state      <= ST_READ;
                              mem_addr_o <= addr_next;
                              mem_re_o   <= 1'b1;
                           end else begin
                              state <= ST_PROG;
                           end
                        end
                     end
                  end
                  ST_READ: begin
                     if (bit_cnt == 3'd7) begin
                        addr       <= addr_inc;
                        mem_addr_o <= addr_inc;
                        mem_re_o   <= 1'b1;
                     end
                  end
                  ST_PROG: begin
                     if (bit_cnt == 3'd7) begin
                        mem_we_o    <= 1'b1;
                        mem_addr_o  <= addr;
                        mem_wdata_o <= rx_next;
                        addr        <= page_inc;
                     end
                  end
                  ST_ID: begin
                     if (bit_cnt == 3'd7) begin
                        byte_cnt  <= id_nxt;
                        shift_out <= id_byte(JEDEC_ID, id_nxt);
                     end
                  end
                  ST_STATUS: begin
                     if (bit_cnt == 3'd7) shift_out <= status_byte;
                  end
                  default: ;
               endcase
            end else if (sck_fall) begin
               if (load_pend) begin
                  miso_o    <= mem_rdata_i[7];
                  shift_out <= {mem_rdata_i[6:0], 1'b0};
               end else begin
                  miso_o    <= shift_out[7];
                  shift_out <= {shift_out[6:0], 1'b0};
               end
            end else if (load_pend) begin
               shift_out <= mem_rdata_i;
            end
         end
      end
   end

endmodule
